// File: rtl/mem_stage_data_port.sv
// MEM pipeline stage: passes non-memory instructions straight to MEM/WB and runs
// one blocking data-memory access at a time, with an ack timeout that completes as a fault.
module mem_stage_data_port #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_mem_valid,
   input  logic [1:0]  ex_mem_op,
   input  logic [7:0]  ex_mem_data_top,
   input  logic [7:0]  ex_mem_data_bot,
   input  logic [7:0]  ex_mem_store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   output logic [7:0]  dmem_wdata,
   input  logic        dmem_ack,
   input  logic [7:0]  dmem_rdata,
   output logic        stall,
   output logic        mem_wb_valid,
   output logic [7:0]  mem_wb_data_top,
   output logic [7:0]  mem_wb_data_bot,
   output logic        mem_fault
);

   localparam int unsigned CNT_W = 4;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   state_t           r_state, w_state;
   logic [CNT_W-1:0] r_cnt, w_cnt;
   logic             r_we, w_we;
   logic [15:0]      r_addr, w_addr;
   logic [7:0]       r_wdata, w_wdata;
   logic             r_wb_valid, w_wb_valid;
   logic [7:0]       r_wb_top, w_wb_top;
   logic [7:0]       r_wb_bot, w_wb_bot;
   logic             r_fault, w_fault;
   logic             w_is_mem;
   logic             w_timeout;
   logic             w_stall;

   assign w_is_mem  = ex_mem_valid && ((ex_mem_op == OP_LOAD) || (ex_mem_op == OP_STORE));
   assign w_timeout = (r_state == ST_ACCESS) && !dmem_ack && (r_cnt == CNT_LAST);

   // Next-state and next-output logic
   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_we       = r_we;
      w_addr     = r_addr;
      w_wdata    = r_wdata;
      w_wb_valid = 1'b0;
      w_wb_top   = r_wb_top;
      w_wb_bot   = r_wb_bot;
      w_fault    = r_fault;
      w_stall    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_is_mem) begin
               w_state = ST_ACCESS;
               w_cnt   = '0;
               w_we    = (ex_mem_op == OP_STORE);
               w_addr  = {ex_mem_data_top, ex_mem_data_bot};
               w_wdata = ex_mem_store_data;
               w_stall = 1'b1;
            end else if (ex_mem_valid) begin
               w_wb_valid = 1'b1;
               w_wb_top   = ex_mem_data_top;
               w_wb_bot   = ex_mem_data_bot;
               w_fault    = 1'b0;
            end
         end
         ST_ACCESS: begin
            // Ack takes priority over a timeout landing in the same cycle
            if (dmem_ack) begin
               w_state    = ST_IDLE;
               w_wb_valid = 1'b1;
               w_fault    = 1'b0;
               w_wb_top   = r_we ? r_addr[15:8] : 8'h00;
               w_wb_bot   = r_we ? r_addr[7:0]  : dmem_rdata;
            end else if (w_timeout) begin
               w_state    = ST_IDLE;
               w_wb_valid = 1'b1;
               w_fault    = 1'b1;
               w_wb_top   = 8'h00;
               w_wb_bot   = 8'h00;
            end else begin
               w_cnt   = r_cnt + 4'd1;
               w_stall = 1'b1;
            end
         end
         default: w_state = ST_IDLE;
      endcase
      if (reset) w_stall = 1'b0;
   end

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_addr     <= 16'h0000;
         r_wdata    <= 8'h00;
         r_wb_valid <= 1'b0;
         r_wb_top   <= 8'h00;
         r_wb_bot   <= 8'h00;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_we       <= w_we;
         r_addr     <= w_addr;
         r_wdata    <= w_wdata;
         r_wb_valid <= w_wb_valid;
         r_wb_top   <= w_wb_top;
         r_wb_bot   <= w_wb_bot;
         r_fault    <= w_fault;
      end
   end

   assign dmem_req        = (r_state == ST_ACCESS);
   assign dmem_we         = r_we;
   assign dmem_addr       = r_addr;
   assign dmem_wdata      = r_wdata;
   assign stall           = w_stall;
   assign mem_wb_valid    = r_wb_valid;
   assign mem_wb_data_top = r_wb_top;
   assign mem_wb_data_bot = r_wb_bot;
   assign mem_fault       = r_fault;

endmodule

// File: tb/tb_mem_stage_data_port.sv
// Bench for mem_stage_data_port: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_mem_stage_data_port;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_mem_valid;
   logic [1:0]  ex_mem_op;
   logic [7:0]  ex_mem_data_top;
   logic [7:0]  ex_mem_data_bot;
   logic [7:0]  ex_mem_store_data;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [7:0]  dmem_wdata;
   logic        dmem_ack;
   logic [7:0]  dmem_rdata;
   logic        stall;
   logic        mem_wb_valid;
   logic [7:0]  mem_wb_data_top;
   logic [7:0]  mem_wb_data_bot;
   logic        mem_fault;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage_data_port #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset),
      .ex_mem_valid(ex_mem_valid), .ex_mem_op(ex_mem_op),
      .ex_mem_data_top(ex_mem_data_top), .ex_mem_data_bot(ex_mem_data_bot),
      .ex_mem_store_data(ex_mem_store_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .mem_wb_valid(mem_wb_valid),
      .mem_wb_data_top(mem_wb_data_top), .mem_wb_data_bot(mem_wb_data_bot),
      .mem_fault(mem_fault)
   );

   always #5 clock = ~clock;

   // Transaction-level model: an outstanding access plus how long it has waited
   bit          m_known = 0;
   bit          m_busy;
   bit          m_store;
   logic [15:0] m_addr;
   logic [7:0]  m_wdata;
   int          m_waited;
   bit          m_wb_valid;
   logic [7:0]  m_top, m_bot;
   bit          m_fault;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_mem_op(input logic [1:0] op);
      return (op == 2'b01) || (op == 2'b10);
   endfunction

   function automatic bit model_stall();
      if (reset) return 1'b0;
      if (!m_busy) return ex_mem_valid && is_mem_op(ex_mem_op);
      return !(dmem_ack || (m_waited + 1 == TMO));
   endfunction

   task automatic compare_model();
      chk("stall", 32'(stall), 32'(model_stall()));
      chk("dmem_req", 32'(dmem_req), 32'(m_busy));
      if (m_busy) begin
         chk("dmem_we", 32'(dmem_we), 32'(m_store));
         chk("dmem_addr", 32'(dmem_addr), 32'(m_addr));
         chk("dmem_wdata", 32'(dmem_wdata), 32'(m_wdata));
      end
      chk("mem_wb_valid", 32'(mem_wb_valid), 32'(m_wb_valid));
      chk("mem_wb_top", 32'(mem_wb_data_top), 32'(m_top));
      chk("mem_wb_bot", 32'(mem_wb_data_bot), 32'(m_bot));
      if (m_wb_valid) chk("mem_fault", 32'(mem_fault), 32'(m_fault));
   endtask

   task automatic drive(input logic rst, input logic v, input logic [1:0] op,
                        input logic [7:0] t, input logic [7:0] b, input logic [7:0] sd,
                        input logic ack, input logic [7:0] rd);
      @(negedge clock);
      reset = rst; ex_mem_valid = v; ex_mem_op = op;
      ex_mem_data_top = t; ex_mem_data_bot = b; ex_mem_store_data = sd;
      dmem_ack = ack; dmem_rdata = rd;
      #1;
      if (m_known) compare_model();
   endtask

   task automatic tick();
      if (reset) begin
         m_known = 1; m_busy = 0; m_store = 0; m_addr = '0; m_wdata = '0;
         m_waited = 0; m_wb_valid = 0; m_top = '0; m_bot = '0; m_fault = 0;
      end else if (!m_busy) begin
         m_wb_valid = 0;
         if (ex_mem_valid && is_mem_op(ex_mem_op)) begin
            m_busy = 1; m_store = (ex_mem_op == 2'b10); m_waited = 0;
            m_addr = {ex_mem_data_top, ex_mem_data_bot}; m_wdata = ex_mem_store_data;
         end else if (ex_mem_valid) begin
            m_wb_valid = 1; m_fault = 0; m_top = ex_mem_data_top; m_bot = ex_mem_data_bot;
         end
      end else if (dmem_ack) begin
         m_busy = 0; m_wb_valid = 1; m_fault = 0;
         m_top = m_store ? m_addr[15:8] : 8'h00;
         m_bot = m_store ? m_addr[7:0] : dmem_rdata;
      end else if (m_waited + 1 == TMO) begin
         m_busy = 0; m_wb_valid = 1; m_fault = 1; m_top = 8'h00; m_bot = 8'h00;
      end else begin
         m_waited++; m_wb_valid = 0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle_cycle();
      drive(0, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 8'h00);
   endtask

   initial begin
      // Reset and reset values
      drive(1, 1, 2'b01, 8'h12, 8'h34, 8'h00, 0, 8'h00);
      tick();
      drive(1, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 8'h00);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk("rst_addr", 32'(dmem_addr), 32'h0000);
      chk("rst_wb_valid", 32'(mem_wb_valid), 32'd0);
      chk("rst_fault", 32'(mem_fault), 32'd0);
      tick();

      // Pass-through
      drive(0, 1, 2'b00, 8'hA5, 8'h3C, 8'h00, 0, 8'h00);
      chk("pt_stall", 32'(stall), 32'd0);
      tick();
      idle_cycle();
      chk("pt_valid", 32'(mem_wb_valid), 32'd1);
      chk("pt_top", 32'(mem_wb_data_top), 32'hA5);
      chk("pt_bot", 32'(mem_wb_data_bot), 32'h3C);
      chk("pt_stall2", 32'(stall), 32'd0);
      tick();

      // Load, ack on the 3rd access cycle
      drive(0, 1, 2'b01, 8'h12, 8'h34, 8'h00, 0, 8'h00);
      chk("ld_stall0", 32'(stall), 32'd1);
      tick();
      for (int i = 1; i <= 3; i++) begin
         drive(0, 0, 2'b00, 8'h00, 8'h00, 8'h00, (i == 3), 8'h7E);
         chk("ld_req", 32'(dmem_req), 32'd1);
         chk("ld_addr", 32'(dmem_addr), 32'h1234);
         chk("ld_we", 32'(dmem_we), 32'd0);
         chk("ld_stall", 32'(stall), (i == 3) ? 32'd0 : 32'd1);
         tick();
      end
      idle_cycle();
      chk("ld_valid", 32'(mem_wb_valid), 32'd1);
      chk("ld_top", 32'(mem_wb_data_top), 32'h00);
      chk("ld_bot", 32'(mem_wb_data_bot), 32'h7E);
      chk("ld_fault", 32'(mem_fault), 32'd0);
      tick();

      // Store with immediate ack
      drive(0, 1, 2'b10, 8'h00, 8'hFF, 8'h55, 0, 8'h00);
      tick();
      drive(0, 0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h00);
      chk("st_req", 32'(dmem_req), 32'd1);
      chk("st_we", 32'(dmem_we), 32'd1);
      chk("st_wdata", 32'(dmem_wdata), 32'h55);
      tick();
      idle_cycle();
      chk("st_valid", 32'(mem_wb_valid), 32'd1);
      chk("st_top", 32'(mem_wb_data_top), 32'h00);
      chk("st_bot", 32'(mem_wb_data_bot), 32'hFF);
      chk("st_req_after", 32'(dmem_req), 32'd0);
      tick();

      // Timeout (no ack) and ack exactly on the timeout cycle
      for (int k = 0; k < 2; k++) begin
         drive(0, 1, 2'b01, 8'hC0, 8'hDE, 8'h00, 0, 8'h00);
         tick();
         for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 2'b00, 8'h00, 8'h00, 8'h00, (k == 1 && i == 4), 8'h99);
            chk("to_req", 32'(dmem_req), 32'd1);
            chk("to_stall", 32'(stall), (i == 4) ? 32'd0 : 32'd1);
            tick();
         end
         idle_cycle();
         chk("to_req_after", 32'(dmem_req), 32'd0);
         chk("to_valid", 32'(mem_wb_valid), 32'd1);
         chk("to_fault", 32'(mem_fault), (k == 0) ? 32'd1 : 32'd0);
         chk("to_top", 32'(mem_wb_data_top), 32'h00);
         chk("to_bot", 32'(mem_wb_data_bot), (k == 0) ? 32'h00 : 32'h99);
         tick();
      end

      // Reset in the 2nd access cycle, late ack afterwards
      drive(0, 1, 2'b10, 8'hAB, 8'hCD, 8'h77, 0, 8'h00);
      tick();
      drive(0, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 8'h00);
      tick();
      drive(1, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 8'h00);
      chk("ra_stall", 32'(stall), 32'd0);
      tick();
      drive(0, 0, 2'b00, 8'h00, 8'h00, 8'h00, 1, 8'h44);
      chk("ra_req", 32'(dmem_req), 32'd0);
      chk("ra_we", 32'(dmem_we), 32'd0);
      chk("ra_addr", 32'(dmem_addr), 32'h0000);
      chk("ra_wdata", 32'(dmem_wdata), 32'h00);
      chk("ra_valid", 32'(mem_wb_valid), 32'd0);
      chk("ra_top", 32'(mem_wb_data_top), 32'h00);
      chk("ra_bot", 32'(mem_wb_data_bot), 32'h00);
      chk("ra_fault", 32'(mem_fault), 32'd0);
      tick();
      idle_cycle();
      chk("ra_late_ack", 32'(mem_wb_valid), 32'd0);
      chk("ra_req2", 32'(dmem_req), 32'd0);
      tick();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 99) == 0),
               ($urandom_range(0, 9) < 7),
               2'($urandom_range(0, 3)),
               8'($urandom), 8'($urandom), 8'($urandom),
               ($urandom_range(0, 9) < 3),
               8'($urandom));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
